color_hist_reader: RTL
======================

// Module: color_hist_reader
// PURPOSE
//  Downstream reader of the per-pixel results written by the k-means/thresholding stage: scans the
//  CIE_AB_COLOR bin memory and the Cluster_ID memory over one image. Builds two 16-bin histograms
//  (a-bin, b-bin) of foreground pixels and streams the 32 counts to the feature classifier over a
//  valid/ready interface.
// PARAMETERS
//  TOTAL_PIXELS  50176    pixels per image; memory addresses 1..TOTAL_PIXELS inclusive
//  COUNT_W       16       width of each histogram counter, saturating
//  BG_CODE       8'h84    colour code written for background pixels (abin=8, bbin=4); never counted
// PORTS
//  clk             in   1        single clock, rising edge
//  reset           in   1        synchronous, active-low reset
//  start_hist      in   1        1-cycle start pulse; accepted only in IDLE
//  COLOR_PORTB_addr out 16       read address into CIE_AB_COLOR memory
//  COLOR_PORTB_din in   8        {abin[7:4], bbin[3:0]}; valid 1 cycle after the address
//  CID_PORTB_addr  out  16       read address into Cluster_ID memory; always equal to COLOR_PORTB_addr
//  CID_PORTB_din   in   1        cluster id, 1 = selected cluster; valid 1 cycle after the address
//  hist_valid      out  1        hist_data/hist_idx/hist_last valid
//  hist_ready      in   1        consumer accepts the beat when hist_valid & hist_ready
//  hist_data       out  COUNT_W  bin count
//  hist_idx        out  5        0..15 = a-bins 0..15; 16..31 = b-bins 0..15
//  hist_last       out  1        high with idx 31
//  fg_count        out  16       number of counted pixels; stable from DONE until the next start
//  busy            out  1        high in every state except IDLE
//  done_hist       out  1        1-cycle pulse after the idx-31 beat is accepted
// BEHAVIOUR
//  Reset (reset==0 at a clk edge) has priority over everything, including mid-operation:
//   - state returns to IDLE; all counters, fg_count and the address clear to 0;
//   - hist_valid, hist_last, busy and done_hist go to 0.
//  FSM:
//   - IDLE -> CLEAR on start_hist.
//   - CLEAR (1 cycle): zero all 32 counters and fg_count; set addr=1.
//   - SCAN: issue addr each cycle. When addr==TOTAL_PIXELS, go to DRAIN; otherwise addr+1.
//   - DRAIN (1 cycle): consume the final read.
//   - STREAM: idx 0..31.
//   - DONE (1 cycle, done_hist=1) -> IDLE.
//  Read pipeline: rd_v register = (state==SCAN), delayed 1 cycle. Data qualifies at rd_v when
//   CID_PORTB_din==1 and COLOR_PORTB_din!=BG_CODE. On a qualified pixel:
//   - a_cnt[din[7:4]] += 1 and b_cnt[din[3:0]] += 1;
//   - fg_count += 1;
//   - every counter saturates at all-ones and never wraps.
//  Address is held at its last value outside SCAN. start_hist is ignored while busy.
//  SCAN lasts exactly TOTAL_PIXELS cycles: pixel at addr k is sampled at cycle k+1 after CLEAR.
//  STREAM handshake:
//   - hist_valid stays high with data held stable until accepted; idx advances only on accept;
//   - hist_ready may be low indefinitely (no timeout);
//   - hist_valid drops the cycle after the idx-31 accept.
//  Total latency with hist_ready tied high:
//   1 (CLEAR) + TOTAL_PIXELS + 1 (DRAIN) + 32 + 1 (DONE) cycles from start accept to done_hist.
// TESTING
//  1. TOTAL_PIXELS=8, all CID=1, colour=8'h35:
//     a_cnt[3]=8, b_cnt[5]=8, all other bins 0, fg_count=8; 32 beats, last at idx 31.
//  2. All pixels colour=BG_CODE or CID=0 -> all 32 counts 0, fg_count=0; done_hist still pulses.
//  3. hist_ready toggled 1,0,0,1 pattern -> no beat lost or duplicated; data held while ready=0.
//  4. COUNT_W=3, 10 pixels all 8'h11, CID=1 -> a_cnt[1]=b_cnt[1]=7 (saturated); fg_count=10.
//  5. reset=0 asserted at addr=5 in SCAN -> next cycle IDLE, busy=0, hist_valid=0;
//     a new start gives a clean histogram.
//  6. start_hist re-pulsed during SCAN and STREAM -> ignored; results identical to a single start.

Source files
------------

// File: rtl/color_hist_reader.sv
// Scans the colour-bin and cluster-id memories over one image, builds 16-bin a/b histograms of
// foreground pixels and streams the 32 saturating counts out over a valid/ready port.
module color_hist_reader #(
   parameter int          TOTAL_PIXELS = 50176,
   parameter int          COUNT_W      = 16,
   parameter logic [7:0]  BG_CODE      = 8'h84
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start_hist,
   output logic [15:0]        COLOR_PORTB_addr,
   input  logic [7:0]         COLOR_PORTB_din,
   output logic [15:0]        CID_PORTB_addr,
   input  logic               CID_PORTB_din,
   output logic               hist_valid,
   input  logic               hist_ready,
   output logic [COUNT_W-1:0] hist_data,
   output logic [4:0]         hist_idx,
   output logic               hist_last,
   output logic [15:0]        fg_count,
   output logic               busy,
   output logic               done_hist
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_SCAN,
      S_DRAIN,
      S_STREAM,
      S_DONE
   } state_t;

   localparam logic [15:0]        LAST_ADDR = 16'(TOTAL_PIXELS);
   localparam logic [COUNT_W-1:0] CNT_ONE   = {{(COUNT_W-1){1'b0}}, 1'b1};
   localparam logic [COUNT_W-1:0] CNT_MAX   = {COUNT_W{1'b1}};

   state_t             state_q, state_d;
   logic [15:0]        addr_q, addr_d;
   logic               rd_v_q;
   logic [4:0]         idx_q, idx_d;
   logic [15:0]        fg_q, fg_d;
   logic [COUNT_W-1:0] a_cnt_q [16];
   logic [COUNT_W-1:0] a_cnt_d [16];
   logic [COUNT_W-1:0] b_cnt_q [16];
   logic [COUNT_W-1:0] b_cnt_d [16];

   logic       accept;
   logic       qualify;
   logic [3:0] abin;
   logic [3:0] bbin;

   // Handshake: a beat transfers on any rising edge where hist_valid & hist_ready; while
   // hist_valid is high and the beat is not taken, data/idx/last are held unchanged.
   assign accept  = hist_valid & hist_ready;
   assign abin    = COLOR_PORTB_din[7:4];
   assign bbin    = COLOR_PORTB_din[3:0];
   // rd_v_q marks the cycle in which the memories return data for the previous scan address.
   assign qualify = rd_v_q & CID_PORTB_din & (COLOR_PORTB_din != BG_CODE);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (start_hist) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            addr_d  = 16'd1;
            state_d = S_SCAN;
         end
         S_SCAN: begin
            if (addr_q == LAST_ADDR) state_d = S_DRAIN;
            else                     addr_d  = addr_q + 16'd1;
         end
         S_DRAIN: begin
            idx_d   = 5'd0;
            state_d = S_STREAM;
         end
         S_STREAM: begin
            if (accept) begin
               if (idx_q == 5'd31) state_d = S_DONE;
               else                idx_d   = idx_q + 5'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      fg_d = fg_q;
      for (int i = 0; i < 16; i++) begin
         a_cnt_d[i] = a_cnt_q[i];
         b_cnt_d[i] = b_cnt_q[i];
      end
      if (state_q == S_CLEAR) begin
         fg_d = 16'd0;
         for (int i = 0; i < 16; i++) begin
            a_cnt_d[i] = '0;
            b_cnt_d[i] = '0;
         end
      end else if (qualify) begin
         // Every counter sticks at all-ones rather than wrapping.
         if (fg_q != 16'hFFFF)          fg_d          = fg_q + 16'd1;
         if (a_cnt_q[abin] != CNT_MAX)  a_cnt_d[abin] = a_cnt_q[abin] + CNT_ONE;
         if (b_cnt_q[bbin] != CNT_MAX)  b_cnt_d[bbin] = b_cnt_q[bbin] + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         addr_q  <= 16'd0;
         rd_v_q  <= 1'b0;
         idx_q   <= 5'd0;
         fg_q    <= 16'd0;
         for (int i = 0; i < 16; i++) begin
            a_cnt_q[i] <= '0;
            b_cnt_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rd_v_q  <= (state_q == S_SCAN);
         idx_q   <= idx_d;
         fg_q    <= fg_d;
         for (int i = 0; i < 16; i++) begin
            a_cnt_q[i] <= a_cnt_d[i];
            b_cnt_q[i] <= b_cnt_d[i];
         end
      end
   end

   assign COLOR_PORTB_addr = addr_q;
   assign CID_PORTB_addr   = addr_q;
   assign hist_valid       = (state_q == S_STREAM);
   assign hist_idx         = idx_q;
   assign hist_data        = idx_q[4] ? b_cnt_q[idx_q[3:0]] : a_cnt_q[idx_q[3:0]];
   assign hist_last        = hist_valid & (idx_q == 5'd31);
   assign fg_count         = fg_q;
   assign busy             = (state_q != S_IDLE);
   assign done_hist        = (state_q == S_DONE);

endmodule
